non_restoring_division_datapath: RTL and testbench

//  Datapath for the unsigned non-restoring divider. Driven cycle-by-cycle by the control path's

---
 rtl/non_restoring_division_datapath.sv | 104 ++++++++++
 tb/tb_non_restoring_division_datapath.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/non_restoring_division_datapath.sv
// Datapath of the unsigned non-restoring divider: A/Q/M registers, iteration counter and result
// registers, sequenced cycle by cycle by the control path's strobes.
module non_restoring_division_datapath #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             count_enable,
    input  logic             select_A,
    input  logic             select_Q,
    input  logic             ld_A,
    input  logic             ld_Q,
    input  logic             select_add,
    input  logic             shift_left_enable_a,
    input  logic             shift_left_enable_q,
    input  logic             ld_rem_quotient,
    output logic             done,
    output logic             status_correctness_check,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             result_valid,
    output logic             div_by_zero
);

    logic [WIDTH:0]   a_reg;
    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] m_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             add_mode_reg;
    logic [WIDTH-1:0] quotient_reg;
    logic [WIDTH-1:0] remainder_reg;
    logic             result_valid_reg;
    logic             div_by_zero_reg;

    logic [WIDTH:0]   m_ext;
    logic [WIDTH:0]   a_plus_m;
    logic [WIDTH:0]   alu_res;
    logic             load_cycle;

    assign m_ext      = {1'b0, m_reg};
    assign a_plus_m   = a_reg + m_ext;
    // add_mode remembers the sign of A before the shift: negative A is restored by adding M
    assign alu_res    = (select_add | add_mode_reg) ? a_plus_m : (a_reg - m_ext);
    assign load_cycle = ld_A & ld_Q & select_A & select_Q;

    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg            <= '0;
            q_reg            <= '0;
            m_reg            <= '0;
            cnt_reg          <= '0;
            add_mode_reg     <= 1'b0;
            quotient_reg     <= '0;
            remainder_reg    <= '0;
            result_valid_reg <= 1'b0;
            div_by_zero_reg  <= 1'b0;
        end else begin
            if (ld_A & select_A & ~select_add)
                a_reg <= '0;
            else if (ld_A & select_A & select_add)
                a_reg <= a_plus_m;
            else if (ld_A & ~select_A)
                a_reg <= alu_res;
            else if (shift_left_enable_a) begin
                a_reg        <= {a_reg[WIDTH-1:0], q_reg[WIDTH-1]};
                add_mode_reg <= a_reg[WIDTH];
            end

            if (ld_Q & select_Q)
                q_reg <= dividend;
            else if (ld_Q & ~select_Q)
                q_reg <= {q_reg[WIDTH-1:1], ~alu_res[WIDTH]};
            else if (shift_left_enable_q)
                q_reg <= {q_reg[WIDTH-2:0], 1'b0};

            if (load_cycle) begin
                m_reg           <= divisor;
                cnt_reg         <= CNT_W'(WIDTH);
                add_mode_reg    <= 1'b0;
                div_by_zero_reg <= (divisor == '0);
            end else if (count_enable && (cnt_reg != '0)) begin
                cnt_reg <= cnt_reg - CNT_W'(1);
            end

            result_valid_reg <= ld_rem_quotient;
            if (ld_rem_quotient) begin
                quotient_reg  <= q_reg;
                remainder_reg <= a_reg[WIDTH-1:0];
            end
        end
    end

    // Asserted while the final iteration runs so the control path can branch on the same cycle
    assign done                     = (cnt_reg == CNT_W'(1));
    assign status_correctness_check = a_reg[WIDTH];
    assign quotient                 = quotient_reg;
    assign remainder                = remainder_reg;
    assign result_valid             = result_valid_reg;
    assign div_by_zero              = div_by_zero_reg;

endmodule

// File: tb/tb_non_restoring_division_datapath.sv
// Directed bench for the non-restoring divider datapath: acts as the control path and checks
// results of 8-bit divides plus an exhaustive 4-bit sweep.
module tb_non_restoring_division_datapath;

    typedef struct packed {
        logic ce, sa, sq, la, lq, sadd, sha, shq, lrq;
    } ctl_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sel4 = 1'b0;
    ctl_t ctl = '0;
    ctl_t ctl8, ctl4;
    logic [7:0] dd8 = '0, dv8 = '0;
    logic [3:0] dd4 = '0, dv4 = '0;

    logic       done8, csc8, rv8, dbz8;
    logic [7:0] quot8, rem8;
    logic       done4, csc4, rv4, dbz4;
    logic [3:0] quot4, rem4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign ctl8 = sel4 ? '0 : ctl;
    assign ctl4 = sel4 ? ctl : '0;

    non_restoring_division_datapath #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .dividend(dd8), .divisor(dv8),
        .count_enable(ctl8.ce), .select_A(ctl8.sa), .select_Q(ctl8.sq),
        .ld_A(ctl8.la), .ld_Q(ctl8.lq), .select_add(ctl8.sadd),
        .shift_left_enable_a(ctl8.sha), .shift_left_enable_q(ctl8.shq),
        .ld_rem_quotient(ctl8.lrq), .done(done8), .status_correctness_check(csc8),
        .quotient(quot8), .remainder(rem8), .result_valid(rv8), .div_by_zero(dbz8)
    );

    non_restoring_division_datapath #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .dividend(dd4), .divisor(dv4),
        .count_enable(ctl4.ce), .select_A(ctl4.sa), .select_Q(ctl4.sq),
        .ld_A(ctl4.la), .ld_Q(ctl4.lq), .select_add(ctl4.sadd),
        .shift_left_enable_a(ctl4.sha), .shift_left_enable_q(ctl4.shq),
        .ld_rem_quotient(ctl4.lrq), .done(done4), .status_correctness_check(csc4),
        .quotient(quot4), .remainder(rem4), .result_valid(rv4), .div_by_zero(dbz4)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One controlled cycle; starts and ends 1 time unit after a rising edge.
    task automatic cyc(input ctl_t c, output logic d, output logic s);
        ctl = c;
        @(negedge clk);
        d = sel4 ? done4 : done8;
        s = sel4 ? csc4 : csc8;
        @(posedge clk);
        #1;
        ctl = '0;
    endtask

    task automatic load(input logic [7:0] dd, input logic [7:0] dv);
        ctl_t c;
        logic d, s;
        dd8 = dd; dv8 = dv; dd4 = dd[3:0]; dv4 = dv[3:0];
        c = '0; c.sa = 1; c.sq = 1; c.la = 1; c.lq = 1;
        cyc(c, d, s);
    endtask

    task automatic iterate(output logic d);
        ctl_t c;
        logic dd, s;
        c = '0; c.sha = 1; cyc(c, dd, s);
        c = '0; c.shq = 1; cyc(c, dd, s);
        c = '0; c.la = 1; c.lq = 1; c.ce = 1; cyc(c, d, s);
    endtask

    task automatic run_div(input int n, input logic [7:0] dd, input logic [7:0] dv,
                           output logic [7:0] q, output logic [7:0] r, output logic [7:0] dmask,
                           output logic done_after, output logic corr,
                           output logic rv_hi, output logic rv_lo);
        ctl_t c;
        logic d, s;
        load(dd, dv);
        dmask = '0;
        for (int i = 0; i < n; i++) begin
            iterate(d);
            dmask[i] = d;
        end
        c = '0; cyc(c, done_after, corr);
        if (corr) begin
            c = '0; c.sa = 1; c.la = 1; c.sadd = 1; cyc(c, d, s);
        end
        c = '0; c.lrq = 1; cyc(c, d, s);
        rv_hi = sel4 ? rv4 : rv8;
        q = sel4 ? {4'b0, quot4} : quot8;
        r = sel4 ? {4'b0, rem4} : rem8;
        c = '0; cyc(c, d, s);
        rv_lo = sel4 ? rv4 : rv8;
    endtask

    typedef struct {
        logic [7:0] dd, dv, q, r;
        logic dbz;
    } vec_t;

    initial begin
        vec_t vecs[5];
        logic [7:0] q, r, dm;
        logic da, corr, rvh, rvl, d;

        vecs[0] = '{8'd100, 8'd7,  8'd14,  8'd2,   1'b0};
        vecs[1] = '{8'd255, 8'd16, 8'd15,  8'd15,  1'b0};
        vecs[2] = '{8'd5,   8'd9,  8'd0,   8'd5,   1'b0};
        vecs[3] = '{8'd200, 8'd0,  8'd255, 8'd200, 1'b1};
        vecs[4] = '{8'd9,   8'd3,  8'd3,   8'd0,   1'b0};

        repeat (2) @(posedge clk);
        #1;
        check("reset_quotient", quot8, 0);
        check("reset_remainder", rem8, 0);
        check("reset_valid", rv8, 0);
        check("reset_done", done8, 0);
        rst = 1'b0;

        for (int i = 0; i < 5; i++) begin
            run_div(8, vecs[i].dd, vecs[i].dv, q, r, dm, da, corr, rvh, rvl);
            $display("div8 %0d / %0d -> q=%0d r=%0d dbz=%0d corr=%0d", vecs[i].dd, vecs[i].dv,
                     q, r, dbz8, corr);
            check("quotient", q, vecs[i].q);
            check("remainder", r, vecs[i].r);
            check("div_by_zero", dbz8, vecs[i].dbz);
            check("done_mask", dm, 8'h80);
            check("done_after_last", da, 0);
            check("valid_pulse_hi", rvh, 1);
            check("valid_pulse_lo", rvl, 0);
            check("quotient_hold", quot8, vecs[i].q);
            if (i == 2) check("correction_taken", corr, 1);
        end

        // Reset in the middle of an iteration clears everything
        load(8'd100, 8'd7);
        for (int i = 0; i < 3; i++) iterate(d);
        rst = 1'b1;
        @(posedge clk);
        #1;
        $display("mid-division reset applied");
        check("rst_quotient", quot8, 0);
        check("rst_remainder", rem8, 0);
        check("rst_valid", rv8, 0);
        check("rst_dbz", dbz8, 0);
        check("rst_done", done8, 0);
        check("rst_status", csc8, 0);
        rst = 1'b0;
        run_div(8, 8'd100, 8'd7, q, r, dm, da, corr, rvh, rvl);
        $display("div8 100 / 7 after reset -> q=%0d r=%0d", q, r);
        check("post_rst_quotient", q, 14);
        check("post_rst_remainder", r, 2);

        sel4 = 1'b1;
        for (int a = 0; a < 16; a++) begin
            for (int b = 1; b < 16; b++) begin
                run_div(4, 8'(a), 8'(b), q, r, dm, da, corr, rvh, rvl);
                $display("div4 %0d / %0d -> q=%0d r=%0d", a, b, q, r);
                check("sweep_quotient", q, 32'(a / b));
                check("sweep_remainder", r, 32'(a % b));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
